// File: rtl/vertex_buffer_ctrl.sv
// Vertex buffer sequencer: loads a partition as 512-bit lines, then serves
// single-value reads in request order under response-credit flow control.
module vertex_buffer_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_lines,
    input  logic              phase_end,
    output logic              busy,
    output logic              done,
    input  logic [511:0]      ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W+5:0] rq_idx,
    input  logic              rq_valid,
    output logic              rq_ready,
    output logic [DATA_W-1:0] rs_data,
    output logic              rs_oob,
    output logic              rs_valid,
    input  logic              rs_ready,
    output logic              oob_err,
    output logic [511:0]      buf_wdata,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic              buf_we,
    output logic [ADDR_W+5:0] buf_raddr,
    input  logic [DATA_W-1:0] buf_rdata
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DRAIN} state_t;

    typedef struct packed {
        logic              oob;
        logic [DATA_W-1:0] data;
    } rsp_t;

    state_t            state, state_nxt;
    logic              done_nxt;
    logic [ADDR_W:0]   nl_q;
    logic [ADDR_W:0]   ld_cnt;
    logic              ld_fin;
    logic              ld_acc, ld_last;
    logic              rq_acc, in_range, pop;
    logic [CW-1:0]     outstanding, out_nxt;
    logic [RD_LAT:0]   vld_pipe;
    logic [RD_LAT:0]   oob_pipe;
    rsp_t              fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     f_cnt;
    rsp_t              push_ent;

    assign busy     = (state != IDLE);
    assign ld_ready = (state == LOAD) && !ld_fin;
    assign rq_ready = (state == SERVE) && (outstanding < CW'(FIFO_DEPTH));
    assign ld_acc   = ld_valid && ld_ready;
    assign ld_last  = (ld_cnt == nl_q - 1'b1);
    assign rq_acc   = rq_valid && rq_ready;
    assign in_range = ({1'b0, rq_idx[ADDR_W+5:6]} < nl_q);
    assign rs_valid = (f_cnt != '0);
    assign pop      = rs_valid && rs_ready;
    assign rs_data  = rs_valid ? fifo_mem[rd_ptr].data : '0;
    assign rs_oob   = rs_valid && fifo_mem[rd_ptr].oob;

    // Credits cover both the read pipeline and the FIFO, so the FIFO never overflows.
    always_comb begin
        out_nxt = outstanding;
        if (rq_acc && !pop)
            out_nxt = outstanding + 1'b1;
        else if (!rq_acc && pop)
            out_nxt = outstanding - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (num_lines == '0) ? SERVE : LOAD;
            LOAD:  if (ld_fin) state_nxt = SERVE;
            SERVE: if (phase_end) state_nxt = DRAIN;
            DRAIN: if (out_nxt == '0) begin
                       state_nxt = IDLE;
                       done_nxt  = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nl_q      <= '0;
            ld_cnt    <= '0;
            ld_fin    <= 1'b0;
            oob_err   <= 1'b0;
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
        end else begin
            buf_we <= ld_acc;
            if (state == IDLE && start) begin
                nl_q    <= num_lines;
                ld_cnt  <= '0;
                ld_fin  <= 1'b0;
                oob_err <= 1'b0;
            end else if (rq_acc && !in_range) begin
                oob_err <= 1'b1;
            end
            if (ld_acc) begin
                buf_waddr <= ld_cnt[ADDR_W-1:0];
                buf_wdata <= ld_data;
                ld_cnt    <= ld_cnt + 1'b1;
                if (ld_last) ld_fin <= 1'b1;
            end
        end
    end

    // Out-of-range requests still travel the pipeline so their slot stays in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe    <= '0;
            oob_pipe    <= '0;
            buf_raddr   <= '0;
            outstanding <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[RD_LAT-1:0], rq_acc};
            oob_pipe    <= {oob_pipe[RD_LAT-1:0], rq_acc && !in_range};
            outstanding <= out_nxt;
            if (rq_acc && in_range) buf_raddr <= rq_idx;
        end
    end

    assign push_ent.oob  = oob_pipe[RD_LAT];
    assign push_ent.data = oob_pipe[RD_LAT] ? '0 : buf_rdata;

    always_ff @(posedge clk) begin
        if (vld_pipe[RD_LAT]) fifo_mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt  <= '0;
        end else begin
            if (vld_pipe[RD_LAT])
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (vld_pipe[RD_LAT] && !pop)
                f_cnt <= f_cnt + 1'b1;
            else if (!vld_pipe[RD_LAT] && pop)
                f_cnt <= f_cnt - 1'b1;
        end
    end

endmodule

// File: doc/vertex_buffer_ctrl.md
# vertex_buffer_ctrl

Sequencer for the 64-bank vertex buffer used by the edge-centric scatter/gather engine. Loads a vertex partition into the buffer as 512-bit lines (64 × 8-bit values per line), then serves single-value read requests from the edge stream with in-order responses. Read throughput is governed by response credits, so downstream backpressure never drops data. Sits between the memory-read stream, the multi-bank buffer ports and the edge processing pipeline.

## Interface
- DATA_W, 8, width of one vertex value; the buffer line is fixed at 512 bits (64 values)
- ADDR_W, 10, buffer line address width; value index is ADDR_W+6 bits
- RD_LAT, 2, buffer read latency in cycles, from buf_raddr to buf_rdata
- FIFO_DEPTH, 8, response FIFO depth; must be ≥ RD_LAT+3

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a partition; sampled in IDLE only
- num_lines  in  ADDR_W+1  lines to load; sampled with start
- phase_end  in  1  no more requests this partition; sampled in SERVE only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the partition completes
- ld_data  in  512  line to load
- ld_valid  in  1  ld_data valid
- ld_ready  out  1  line accepted when ld_valid && ld_ready
- rq_idx  in  ADDR_W+6  value index: line = [ADDR_W+5:6], bank = [5:0]
- rq_valid  in  1  request valid
- rq_ready  out  1  request accepted when rq_valid && rq_ready
- rs_data  out  DATA_W  response value
- rs_oob  out  1  response was out of range; rs_data = 0
- rs_valid  out  1  response valid
- rs_ready  in  1  response consumed when rs_valid && rs_ready
- oob_err  out  1  sticky; set by any out-of-range request, cleared by start or rst
- buf_wdata  out  512  buffer write line
- buf_waddr  out  ADDR_W  buffer write line address
- buf_we  out  1  buffer write enable
- buf_raddr  out  ADDR_W+6  buffer read index
- buf_rdata  in  DATA_W  buffer read value

## Operation
- States: IDLE, LOAD, SERVE, DRAIN.
- IDLE: on start, latch num_lines and clear oob_err and the line counter.
  - num_lines = 0: go to SERVE.
  - Otherwise: go to LOAD.
- LOAD: ld_ready = 1. Each accepted beat is written to line = counter, and the counter increments.
  - After the beat where counter = num_lines−1 is accepted, ld_ready drops the next cycle.
  - The state moves to SERVE one cycle after the final buf_we pulse.
- SERVE: rq_ready = 1 when outstanding < FIFO_DEPTH.
  - outstanding = requests accepted and not yet popped from the response FIFO.
  - In range (line field < num_lines): issue to the buffer; the response takes buf_rdata.
  - Out of range: no buffer read is issued, rs_oob = 1, rs_data = 0, oob_err is set. The response keeps its slot in order.
  - Responses are returned strictly in request order. Nothing is dropped or duplicated.
- phase_end in SERVE: go to DRAIN with rq_ready = 0. If phase_end and a request handshake occur in the same cycle, that request is accepted.
- DRAIN: when outstanding = 0, pulse done for one cycle and go to IDLE.
- start outside IDLE and phase_end outside SERVE are ignored.
- ld_valid while not in LOAD is not accepted.
- outstanding is ADDR-independent: a 4-bit counter (sized log2(FIFO_DEPTH)+1). Increment on accept, decrement on pop; simultaneous accept and pop leave it unchanged.
- rst in any state:
  - go to IDLE;
  - flush the FIFO and read pipeline;
  - zero all counters and oob_err.
  An in-flight buffer read is discarded.

## Timing
- Reset values: busy, done, ld_ready, rq_ready, rs_valid, rs_oob, oob_err and buf_we = 0. rs_data, buf_wdata, buf_waddr and buf_raddr = 0.
- start at cycle t (IDLE): busy = 1 and ld_ready = 1 at t+1.
- Load writes are registered. A beat accepted at k gives buf_we = 1 with buf_waddr and buf_wdata valid at k+1.
- Final load beat accepted at k: last write at k+1, SERVE and first possible rq_ready = 1 at k+2.
- Request accepted at c:
  - buf_raddr valid at c+1;
  - buf_rdata captured into the FIFO at c+1+RD_LAT;
  - rs_valid at c+2+RD_LAT (c+4 at default).
- Out-of-range responses have the same latency as in-range responses.
- Throughput: with rs_ready held high, one request is accepted per cycle indefinitely.
- rs_valid, rs_data and rs_oob are held stable while rs_ready = 0.
- done asserts the cycle after outstanding reaches 0 in DRAIN. State is IDLE and busy = 0 in the same cycle as done.

## Test plan
- Load and read: num_lines = 2, lines filled with byte b = index. Read idx 0, 63, 64, 127 with rs_ready high → rs_data 0x00, 0x3F, 0x40, 0x7F. Each response arrives 4 cycles after its accept, with rs_oob = 0.
- Out of range: num_lines = 1. Requests idx 5, 64, 6 → responses 5, (0, oob = 1), 6 in that order, and oob_err = 1. A following start clears oob_err.
- Backpressure: stream 20 back-to-back requests with rs_ready low for 10 cycles. rq_ready drops after 8 outstanding. All 20 responses arrive in order with none lost, and outstanding never exceeds 8.
- Drain: phase_end asserted while 5 responses are pending with rs_ready toggling. done pulses exactly once, 1 cycle after the last pop, and busy = 0 in the same cycle as done.
- Zero lines: start with num_lines = 0 → SERVE at t+1 with no buf_we. Every request returns rs_oob = 1.
- Reset mid-operation: rst in LOAD after 3 beats, and separately in SERVE with 3 pending. Next cycle all outputs are at reset values. A fresh partition then runs correctly with no stale responses.
